// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// The optional per-output transfer counters are enabled with STREAM_DEMUX_CNT_EN.
package stream_demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] dest_t;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle for the demux: one input stream, four output streams.
// The producer/consumer side uses master, the demux uses slave.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int W = 4
);

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    dest_t                in_sel;
    logic [N_OUT-1:0]     out_valid;
    logic [N_OUT-1:0]     out_ready;
    logic [N_OUT*W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/stream_reg_slot.sv
// Single-entry registered output buffer with a full flag.
module stream_reg_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // A load wins over a drain, so accept+drain in one cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= data_in;
        end else if (r_full && ready) begin
            r_full <= 1'b0;
        end
    end

    assign valid = r_full;
    assign data  = r_data;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer with one registered slot per output.
// STREAM_DEMUX_CNT_EN adds out_cnt, wrapping 8-bit per-output accept counters.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_demux_if.slave            bus
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0]   out_cnt
`endif
);

    dest_t              w_sel;
    logic               w_inReady;
    logic               w_accept;
    logic [N_OUT-1:0]   w_load;
    logic [N_OUT-1:0]   w_full;
    logic [N_OUT*W-1:0] w_outData;

    assign w_sel = bus.in_sel;

    // Readiness looks only at the selected destination, never the other three.
    always_comb begin
        w_inReady = 1'b1;
        case (w_sel)
            2'd0: w_inReady = ~w_full[0] | bus.out_ready[0];
            2'd1: w_inReady = ~w_full[1] | bus.out_ready[1];
            2'd2: w_inReady = ~w_full[2] | bus.out_ready[2];
            2'd3: w_inReady = ~w_full[3] | bus.out_ready[3];
        endcase
    end

    assign w_accept = bus.in_valid & w_inReady;

    always_comb begin
        w_load = '0;
        case (w_sel)
            2'd0: w_load[0] = w_accept;
            2'd1: w_load[1] = w_accept;
            2'd2: w_load[2] = w_accept;
            2'd3: w_load[3] = w_accept;
        endcase
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        stream_reg_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (w_load[i]),
            .data_in (bus.in_data),
            .valid   (w_full[i]),
            .ready   (bus.out_ready[i]),
            .data    (w_outData[i*W +: W])
        );
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_full;
    assign bus.out_data  = w_outData;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt [N_OUT];

    // Counts accepted words per destination, independent of draining; wraps at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_load[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < N_OUT; i++) out_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios plus randomized
// traffic scored against per-output word queues. Counter checks need STREAM_DEMUX_CNT_EN.
module tb_stream_demux_1_4;
    import stream_demux_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Reference: each output is a FIFO of words accepted but not yet taken.
    logic [W-1:0] q [N_OUT][$];
    int           cnt [N_OUT];

    always #5 clk = ~clk;

    stream_demux_if #(.W(W)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
    logic [N_OUT*CNT_W-1:0] out_cnt;
`endif

    stream_demux_1_4 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .out_cnt (out_cnt)
`endif
    );

    task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                         input dest_t s, input logic [N_OUT-1:0] ordy);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        #1;
    endtask

    function automatic logic model_ready();
        return (q[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
    endfunction

    task automatic advance();
        logic acc;
        acc = bus.in_valid && model_ready();
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                q[i].delete();
                cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (q[i].size() != 0 && bus.out_ready[i]) void'(q[i].pop_front());
            end
            if (acc) begin
                q[bus.in_sel].push_back(bus.in_data);
                cnt[bus.in_sel] = (cnt[bus.in_sel] + 1) % 256;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, '0, 2'd0, 4'h0); advance();
        drive(1'b1, 1'b0, '0, 2'd0, 4'h0); advance();
        drive(1'b0, 1'b0, '0, 2'd0, 4'hf);
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready);
        end
`ifdef STREAM_DEMUX_CNT_EN
        checks++;
        if (out_cnt !== '0) begin
            errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", out_cnt);
        end
`endif
        advance();
    endtask

    task automatic test_fanout();
        logic [W-1:0] expd;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(1'b0, 1'b1, W'(4'ha + k), dest_t'(k), 4'hf);
            else       drive(1'b0, 1'b0, '0, 2'd0, 4'hf);
            if (k < 4) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("[TB] FAIL fanout_ready k=%0d: got %b expected 1", k, bus.in_ready);
                end
            end
            if (k > 0) begin
                expd = W'(4'ha + k - 1);
                checks++;
                if (bus.out_valid !== (4'b0001 << (k - 1))) begin
                    errors++; $display("[TB] FAIL fanout_valid k=%0d: got %b expected %b",
                                       k, bus.out_valid, 4'b0001 << (k - 1));
                end
                checks++;
                if (bus.out_data[(k-1)*W +: W] !== expd) begin
                    errors++; $display("[TB] FAIL fanout_data k=%0d: got %h expected %h",
                                       k, bus.out_data[(k-1)*W +: W], expd);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 4'h5, 2'd2, 4'b1011);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_first_ready: got %b expected 1", bus.in_ready);
        end
        advance();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1, 4'h6, 2'd2, 4'b1011);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_blocked j=%0d: got %b expected 0", j, bus.in_ready);
            end
            checks++;
            if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*W +: W] !== 4'h5) begin
                errors++; $display("[TB] FAIL stall_hold j=%0d: got v=%b d=%h expected v=1 d=5",
                                   j, bus.out_valid[2], bus.out_data[2*W +: W]);
            end
            advance();
        end
        drive(1'b0, 1'b1, 4'h6, 2'd2, 4'b1111);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_data[2*W +: W] !== 4'h5) begin
            errors++; $display("[TB] FAIL stall_release: got rdy=%b d=%h expected rdy=1 d=5",
                               bus.in_ready, bus.out_data[2*W +: W]);
        end
        advance();
        drive(1'b0, 1'b1, 4'h7, 2'd0, 4'b1111);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0100 || bus.out_data[2*W +: W] !== 4'h6) begin
            errors++; $display("[TB] FAIL stall_second: got rdy=%b v=%b d=%h expected rdy=1 v=0100 d=6",
                               bus.in_ready, bus.out_valid, bus.out_data[2*W +: W]);
        end
        advance();
        drive(1'b0, 1'b0, '0, 2'd0, 4'b1111);
        checks++;
        if (bus.out_valid !== 4'b0001 || bus.out_data[0 +: W] !== 4'h7) begin
            errors++; $display("[TB] FAIL stall_third: got v=%b d=%h expected v=0001 d=7",
                               bus.out_valid, bus.out_data[0 +: W]);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [8];
        for (int k = 0; k < 8; k++) words[k] = W'($urandom);
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive(1'b0, 1'b1, words[k], 2'd1, 4'hf);
            else       drive(1'b0, 1'b0, '0, 2'd0, 4'hf);
            if (k < 8) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_ready k=%0d: got %b expected 1", k, bus.in_ready);
                end
            end
            if (k > 0) begin
                checks++;
                if (bus.out_valid !== 4'b0010 || bus.out_data[W +: W] !== words[k-1]) begin
                    errors++; $display("[TB] FAIL b2b_out k=%0d: got v=%b d=%h expected v=0010 d=%h",
                                       k, bus.out_valid, bus.out_data[W +: W], words[k-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < N_OUT; k++) begin
            drive(1'b0, 1'b1, W'($urandom), dest_t'(k), 4'h0);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL rstmid_fill k=%0d: got %b expected 1", k, bus.in_ready);
            end
            advance();
        end
        drive(1'b0, 1'b0, '0, 2'd0, 4'h0);
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++; $display("[TB] FAIL rstmid_full: got %b expected 1111", bus.out_valid);
        end
        advance();
        drive(1'b1, 1'b1, 4'h9, 2'd0, 4'hf);
        advance();
        drive(1'b0, 1'b0, '0, 2'd0, 4'h0);
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_after: got v=%b d=%h rdy=%b expected v=0000 d=0 rdy=1",
                               bus.out_valid, bus.out_data, bus.in_ready);
        end
        advance();
    endtask

    task automatic test_random();
        logic         pending;
        logic         v;
        logic [W-1:0] d;
        dest_t        s;
        logic [3:0]   r;
        pending = 1'b0;
        v = 1'b0; d = '0; s = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
                s = dest_t'($urandom_range(0, 3));
            end
            for (int i = 0; i < N_OUT; i++) r[i] = ($urandom_range(0, 2) != 0);
            drive(1'b0, v, d, s, r);
            checks++;
            if (bus.in_ready !== model_ready()) begin
                errors++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, bus.in_ready, model_ready());
            end
            for (int i = 0; i < N_OUT; i++) begin
                checks++;
                if (bus.out_valid[i] !== (q[i].size() != 0)) begin
                    errors++; $display("[TB] FAIL rand_valid c=%0d i=%0d: got %b expected %b",
                                       c, i, bus.out_valid[i], q[i].size() != 0);
                end else if (q[i].size() != 0 && bus.out_data[i*W +: W] !== q[i][0]) begin
                    errors++; $display("[TB] FAIL rand_data c=%0d i=%0d: got %h expected %h",
                                       c, i, bus.out_data[i*W +: W], q[i][0]);
                end
            end
`ifdef STREAM_DEMUX_CNT_EN
            for (int i = 0; i < N_OUT; i++) begin
                checks++;
                if (out_cnt[i*CNT_W +: CNT_W] !== CNT_W'(cnt[i])) begin
                    errors++; $display("[TB] FAIL rand_cnt c=%0d i=%0d: got %0d expected %0d",
                                       c, i, out_cnt[i*CNT_W +: CNT_W], cnt[i]);
                end
            end
`endif
            pending = v && !model_ready();
            advance();
        end
        drive(1'b0, 1'b0, '0, 2'd0, 4'hf);
        advance();
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_counter();
        drive(1'b1, 1'b0, '0, 2'd0, 4'hf); advance();
        for (int k = 0; k < 257; k++) begin
            drive(1'b0, 1'b1, W'($urandom), 2'd3, 4'hf);
            advance();
        end
        drive(1'b0, 1'b0, '0, 2'd0, 4'hf);
        checks++;
        if (out_cnt !== {8'd1, 8'd0, 8'd0, 8'd0}) begin
            errors++; $display("[TB] FAIL cnt_wrap: got %h expected 01000000", out_cnt);
        end
        checks++;
        if (out_cnt[3*CNT_W +: CNT_W] !== CNT_W'(cnt[3])) begin
            errors++; $display("[TB] FAIL cnt_model: got %0d expected %0d", out_cnt[3*CNT_W +: CNT_W], cnt[3]);
        end
        advance();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = '0;
        for (int i = 0; i < N_OUT; i++) cnt[i] = 0;
        test_reset();
        test_fanout();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef STREAM_DEMUX_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
Sequential inverse of the 4:1 case-mux: takes one valid/ready input stream and delivers each word to one of four output streams, chosen by a per-word select field. Each output has a one-entry registered buffer, so a word appears one clock after it is accepted. It sits between a single producer and four independent consumers that can stall separately.

Parameters:
W, 4, data width in bits of every stream.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input word present.
in_ready  output  1  block accepts the input word this cycle.
in_data  input  W  input word.
in_sel  input  2  destination index 0..3; must be stable while in_valid=1 and in_ready=0.
out_valid  output  4  bit i: output i buffer holds a word.
out_ready  input  4  bit i: consumer i takes the word.
out_data  output  4*W  bits [i*W +: W] hold the word for output i.

Behaviour:
- Transfer on input when in_valid && in_ready. Transfer on output i when out_valid[i] && out_ready[i].
- Per output i there is a buffer register and a full flag. out_valid[i] = full[i]. out_data slice i = buffer i.
- in_ready is combinational: ~full[in_sel] | out_ready[in_sel]. in_ready depends only on the selected output, never on the other three. in_ready may be high while in_valid=0.
- Accepting a word for destination s: buffer s <= in_data; full[s] <= 1 at the next edge.
- Latency is 1 clock from input transfer to out_valid. Full throughput on one output: accept and drain in the same cycle keeps full[s]=1 and loads the new word.
- Draining output i with no load for i: full[i] <= 0 at the next edge. The buffer contents are held, but their value is don't-care.
- Other outputs are unaffected by a transfer to s. Outputs drain concurrently, up to all four in one cycle.
- Word order is preserved per output. There is no ordering guarantee across outputs.
- A stalled output blocks only words selected to it. The input stalls; the block never drops or duplicates a word.
- The block is combinationally transparent to neither data nor valid; outputs are registered.
- Reset: full[3:0] <= 0, so out_valid=0. Buffers reset to 0, so out_data=0. in_ready after reset is 1.
- Reset mid-operation: buffered words are discarded. A transfer presented in the reset cycle is ignored, even if in_ready reads 1.
- There is no FSM beyond the four full flags. The selection logic uses a case on in_sel with all four arms; there is no default-induced latch.

Optional Feature:
Macro STREAM_DEMUX_CNT_EN.
- Defined: adds output port out_cnt, 4*8 bits. Slice i is a wrapping 8-bit count of input transfers routed to output i. It increments at the edge after each accepted word (255 -> 0), resets to 0 on rst, and counts independently of draining.
- Undefined: the port and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package stream_demux_pkg holds: localparam N_OUT = 4; localparam SEL_W = 2; localparam CNT_W = 8; typedef logic [SEL_W-1:0] dest_t.
- One natural sub-module is stream_reg_slot. It is the single-entry buffer with full flag, parameterised by W, with ports clk, rst, load, data_in, valid, ready, data. It is instantiated four times via generate.
- Top level contains only select decode, in_ready mux, and the optional counters.

Test Plan:
1. Reset with in_valid=0 -> out_valid=0000, out_data all 0, in_ready=1. With CNT_EN, out_cnt=0.
2. out_ready=1111; send 'ha,'hb,'hc,'hd with sel 0,1,2,3 on consecutive cycles -> each appears on its output exactly one cycle after acceptance, and in_ready stays 1.
3. out_ready[2]=0; send 'h5 sel 2, then 'h6 sel 2, then 'h7 sel 0. Required response:
   - 'h5 is held on output 2.
   - in_ready=0 while 'h6 waits, and 'h7 is blocked behind it.
   - Raising out_ready[2] delivers 'h5 then 'h6 in order, then 'h7 on output 0.
4. Back-to-back stream of 8 words to sel 1 with out_ready[1]=1 -> 8 consecutive transfers with no bubble; output 1 shows the words in order, each one cycle late.
5. Fill all four outputs with out_ready=0, assert rst for one cycle while in_valid=1 -> out_valid=0000 next cycle, no word delivered, in_ready=1.
6. CNT_EN defined: send 257 words to sel 3 -> out_cnt[3]=1, other counts 0.
